// File: rtl/riscv_alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU opcodes,
// default widths, the arbiter state encoding and the multi-cycle opcode test.
// Optional build macro used elsewhere: RISCV_ALU_ARB_FIXED_PRI_EN.
package riscv_alu_pkg;

    localparam int ALU_WIDTH_DEF      = 32;
    localparam int ALU_CTRL_WIDTH_DEF = 5;
    localparam int FLAGS_WIDTH        = 4;
    localparam int CNT_WIDTH          = 4;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_MUL  = 5'b00101;
    localparam logic [4:0] OP_DIV  = 5'b00110;
    localparam logic [4:0] OP_DIVU = 5'b00111;
    localparam logic [4:0] OP_REM  = 5'b01000;
    localparam logic [4:0] OP_REMU = 5'b01001;
    localparam logic [4:0] OP_SLL  = 5'b01010;
    localparam logic [4:0] OP_SRL  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100;
    localparam logic [4:0] OP_SLT  = 5'b01101;
    localparam logic [4:0] OP_SLTU = 5'b01110;
    localparam logic [4:0] OP_SGE  = 5'b01111;
    localparam logic [4:0] OP_SGEU = 5'b10000;
    localparam logic [4:0] OP_MULH = 5'b10001;
    localparam logic [4:0] OP_SEQ  = 5'b10010;
    localparam logic [4:0] OP_SNE  = 5'b10011;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // The divide/remainder family occupies the ALU for several cycles;
    // everything else, including undefined opcodes, is a single-cycle op.
    function automatic logic is_multicycle(input logic [31:0] ctrl);
        return (ctrl >= 32'(OP_DIV)) && (ctrl <= 32'(OP_REMU));
    endfunction

endpackage

// File: rtl/riscv_alu_arbiter_if.sv
// Bundle of request, ALU and response signals between two requesters,
// the shared ALU and the arbiter. The arbiter uses the slave view.
interface riscv_alu_arbiter_if
    import riscv_alu_pkg::*;
#(
    parameter int ALU_WIDTH      = ALU_WIDTH_DEF,
    parameter int ALU_CTRL_WIDTH = ALU_CTRL_WIDTH_DEF
);
    logic [1:0]                     req_valid;
    logic [1:0]                     req_ready;
    logic [1:0][ALU_CTRL_WIDTH-1:0] req_ctrl;
    logic [1:0][ALU_WIDTH-1:0]      req_ina;
    logic [1:0][ALU_WIDTH-1:0]      req_inb_reg;
    logic [1:0][ALU_WIDTH-1:0]      req_inb_imm;
    logic [1:0]                     req_alusrc;

    logic [ALU_CTRL_WIDTH-1:0]      alu_ctrl;
    logic [ALU_WIDTH-1:0]           alu_ina;
    logic [ALU_WIDTH-1:0]           alu_inb_reg;
    logic [ALU_WIDTH-1:0]           alu_inb_imm;
    logic                           alu_alusrc;
    logic [ALU_WIDTH-1:0]           alu_out;
    logic                           alu_overflow;
    logic                           alu_carry;
    logic                           alu_negative;
    logic                           alu_zero;

    logic                           rsp_valid;
    logic                           rsp_id;
    logic [ALU_WIDTH-1:0]           rsp_data;
    logic [FLAGS_WIDTH-1:0]         rsp_flags;
    logic                           rsp_ready;

    modport slave (
        input  req_valid, req_ctrl, req_ina, req_inb_reg, req_inb_imm, req_alusrc,
        output req_ready,
        output alu_ctrl, alu_ina, alu_inb_reg, alu_inb_imm, alu_alusrc,
        input  alu_out, alu_overflow, alu_carry, alu_negative, alu_zero,
        output rsp_valid, rsp_id, rsp_data, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_ctrl, req_ina, req_inb_reg, req_inb_imm, req_alusrc,
        input  req_ready,
        input  alu_ctrl, alu_ina, alu_inb_reg, alu_inb_imm, alu_alusrc,
        output alu_out, alu_overflow, alu_carry, alu_negative, alu_zero,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags,
        output rsp_ready
    );

endinterface

// File: rtl/riscv_alu_arbiter_rr.sv
// Two-way grant selection for the ALU arbiter. Default build is round-robin
// with a one-bit pointer; defining RISCV_ALU_ARB_FIXED_PRI_EN makes
// requester 0 always win and removes the pointer.
module riscv_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_id
);

`ifdef RISCV_ALU_ARB_FIXED_PRI_EN

    // Requester 1 only wins when requester 0 is not asking.
    assign grant_id = req[1] & ~req[0];

    logic unused_rr;
    assign unused_rr = &{1'b0, clk, reset, accept};

`else

    logic prio_q;
    logic prio_d;

    // A lone requester wins outright; on a tie the pointer decides.
    always_comb begin
        grant_id = 1'b0;
        case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = prio_q;
            default: grant_id = 1'b0;
        endcase
    end

    // Only a real accept moves the pointer, handing priority to the other side.
    always_comb begin
        prio_d = accept ? ~grant_id : prio_q;
    end

    // Pointer register; after reset requester 0 is favoured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

`endif

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Shares one combinational ALU between two requesters. A request is latched,
// held on the ALU inputs for its occupancy, and the result is returned with
// the requester id. Optional macro: RISCV_ALU_ARB_FIXED_PRI_EN (fixed priority
// to requester 0 instead of round-robin).
module riscv_alu_arbiter
    import riscv_alu_pkg::*;
#(
    parameter int ALU_WIDTH      = ALU_WIDTH_DEF,
    parameter int ALU_CTRL_WIDTH = ALU_CTRL_WIDTH_DEF,
    parameter int DIV_CYCLES     = 4
) (
    input logic                clk,
    input logic                reset,
    riscv_alu_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = ARB_IDLE;
    localparam logic [1:0] S_EXEC = ARB_EXEC;
    localparam logic [1:0] S_RESP = ARB_RESP;

    localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES);

    logic [1:0]                state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      id_q, id_d;
    logic [ALU_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [ALU_WIDTH-1:0]      ina_q, ina_d;
    logic [ALU_WIDTH-1:0]      inb_reg_q, inb_reg_d;
    logic [ALU_WIDTH-1:0]      inb_imm_q, inb_imm_d;
    logic                      alusrc_q, alusrc_d;
    logic                      rsp_id_q, rsp_id_d;
    logic [ALU_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [FLAGS_WIDTH-1:0]    rsp_flags_q, rsp_flags_d;

    logic                      grant_id;
    logic [1:0]                req_ready;
    logic                      accept;

    riscv_rr_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req_valid),
        .accept   (accept),
        .grant_id (grant_id)
    );

    // Ready is offered only in IDLE, only to the granted requester, and is
    // forced low while reset is held so nothing can be accepted then.
    always_comb begin
        req_ready = 2'b00;
        if (reset && (state_q == S_IDLE)) begin
            req_ready = bus.req_valid & (grant_id ? 2'b10 : 2'b01);
        end
    end

    assign accept        = |req_ready;
    assign bus.req_ready = req_ready;

    assign bus.alu_ctrl    = ctrl_q;
    assign bus.alu_ina     = ina_q;
    assign bus.alu_inb_reg = inb_reg_q;
    assign bus.alu_inb_imm = inb_imm_q;
    assign bus.alu_alusrc  = alusrc_q;

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;

    // Next-state logic. The counter reads 0 in the first EXEC cycle, which is
    // where the occupancy is loaded; the result is captured when it reaches 1,
    // giving occupancy+1 cycles from accept to response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        ctrl_d      = ctrl_q;
        ina_d       = ina_q;
        inb_reg_d   = inb_reg_q;
        inb_imm_d   = inb_imm_q;
        alusrc_d    = alusrc_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_EXEC;
                    cnt_d     = '0;
                    id_d      = grant_id;
                    ctrl_d    = bus.req_ctrl[grant_id];
                    ina_d     = bus.req_ina[grant_id];
                    inb_reg_d = bus.req_inb_reg[grant_id];
                    inb_imm_d = bus.req_inb_imm[grant_id];
                    alusrc_d  = bus.req_alusrc[grant_id];
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    cnt_d = is_multicycle(32'(ctrl_q)) ? DIV_LOAD : CNT_WIDTH'(1);
                end else if (cnt_q == CNT_WIDTH'(1)) begin
                    cnt_d       = '0;
                    state_d     = S_RESP;
                    rsp_id_d    = id_q;
                    rsp_data_d  = bus.alu_out;
                    rsp_flags_d = {bus.alu_overflow, bus.alu_carry,
                                   bus.alu_negative, bus.alu_zero};
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, operand and response registers; reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            ctrl_q      <= '0;
            ina_q       <= '0;
            inb_reg_q   <= '0;
            inb_imm_q   <= '0;
            alusrc_q    <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            ctrl_q      <= ctrl_d;
            ina_q       <= ina_d;
            inb_reg_q   <= inb_reg_d;
            inb_imm_q   <= inb_imm_d;
            alusrc_q    <= alusrc_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

endmodule
